// File: rtl/key_ctrl_pkg.sv
// Shared types and constants for the key PIO controller: FSM states and PIO register map.
package key_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_IRQ,
    ST_DISARM,
    ST_DEBOUNCE,
    ST_SAMPLE,
    ST_CHECK,
    ST_HELD,
    ST_POLL_S,
    ST_POLL_C,
    ST_SETTLE,
    ST_STOP
  } state_t;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;

  // States that spend their single cycle driving an irq-mask write.
  function automatic logic is_mask_write(state_t s);
    return (s == ST_ARM) || (s == ST_DISARM) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/key_pio_ctrl_if.sv
// Avalon-MM link between the key controller (master) and the single-bit key PIO (slave).
interface key_pio_ctrl_if;
  // Handshake: no waitrequest. A write is accepted in the one cycle where
  // m_chipselect=1 and m_write_n=0. Reads need no strobe: the slave registers
  // m_readdata from m_address every cycle, so data is valid one cycle later.
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        irq_in;

  modport master (
    output m_address, m_chipselect, m_write_n, m_writedata,
    input  m_readdata, irq_in
  );

  modport slave (
    input  m_address, m_chipselect, m_write_n, m_writedata,
    output m_readdata, irq_in
  );
endinterface

// File: rtl/key_ctrl_timer.sv
// Loadable down-counter that stops at zero; done flags an expired count not being reloaded.
module key_ctrl_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0) && !load;

endmodule

// File: rtl/key_pio_ctrl.sv
// Key PIO sequencer: arms the irq mask, debounces a press, confirms it by reading the data
// register, polls for release, then re-arms. Emits press/release pulses and a debounced level.
module key_pio_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int POLL_CYCLES     = 50000,
  parameter int CNT_W           = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  key_pio_ctrl_if.master        bus,
  output logic                  key_down,
  output logic                  press_pulse,
  output logic                  release_pulse,
  output logic [15:0]           press_count,
  output state_t                state
);

  state_t           nxt;
  logic             timer_load;
  logic             timer_done;
  logic [CNT_W-1:0] timer_value;
  logic             rd_bit;
  logic             unused_rd;
  logic             press_evt;
  logic             release_evt;

  assign rd_bit    = bus.m_readdata[0];
  assign unused_rd = ^bus.m_readdata[31:1];

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:     if (enable) nxt = ST_ARM;
      ST_ARM:      nxt = enable ? ST_WAIT_IRQ : ST_STOP;
      ST_WAIT_IRQ: if (!enable) nxt = ST_STOP;
                   else if (bus.irq_in) nxt = ST_DISARM;
      ST_DISARM:   nxt = enable ? ST_DEBOUNCE : ST_STOP;
      ST_DEBOUNCE: if (!enable) nxt = ST_STOP;
                   else if (timer_done) nxt = ST_SAMPLE;
      ST_SAMPLE:   nxt = enable ? ST_CHECK : ST_STOP;
      ST_CHECK:    if (!enable) nxt = ST_STOP;
                   else nxt = rd_bit ? ST_HELD : ST_ARM;
      ST_HELD:     if (!enable) nxt = ST_STOP;
                   else if (timer_done) nxt = ST_POLL_S;
      ST_POLL_S:   nxt = enable ? ST_POLL_C : ST_STOP;
      ST_POLL_C:   if (!enable) nxt = ST_STOP;
                   else nxt = rd_bit ? ST_HELD : ST_SETTLE;
      ST_SETTLE:   if (!enable) nxt = ST_STOP;
                   else if (timer_done) nxt = ST_ARM;
      ST_STOP:     nxt = ST_IDLE;
      default:     nxt = ST_IDLE;
    endcase
  end

  // Reloads are harmless when the FSM leaves these states for ARM or STOP instead.
  assign timer_load  = (state == ST_DISARM) || (state == ST_CHECK) || (state == ST_POLL_C);
  assign timer_value = (nxt == ST_HELD) ? CNT_W'(POLL_CYCLES - 1) : CNT_W'(DEBOUNCE_CYCLES - 1);

  assign press_evt   = (state == ST_CHECK) && (nxt == ST_HELD);
  assign release_evt = key_down && ((nxt == ST_SETTLE) || (nxt == ST_STOP));

  key_ctrl_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      bus.m_address    <= PIO_ADDR_DATA;
      bus.m_chipselect <= 1'b0;
      bus.m_write_n    <= 1'b1;
      bus.m_writedata  <= '0;
      key_down         <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      press_count      <= '0;
    end else begin
      state            <= nxt;
      bus.m_chipselect <= is_mask_write(nxt);
      bus.m_write_n    <= !is_mask_write(nxt);
      bus.m_writedata  <= {31'd0, nxt == ST_ARM};
      if (is_mask_write(nxt)) begin
        bus.m_address <= PIO_ADDR_IRQMASK;
      end else if ((nxt == ST_SAMPLE) || (nxt == ST_POLL_S)) begin
        bus.m_address <= PIO_ADDR_DATA;
      end
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
      if (press_evt) begin
        key_down    <= 1'b1;
        press_count <= press_count + 16'd1;
      end else if (release_evt) begin
        key_down <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_pio_ctrl.sv
// Bench for key_pio_ctrl: behavioural key PIO slave, write/pulse monitors, and directed plus
// randomized key waveforms checked against timing and event rules for the controller.
module tb_key_pio_ctrl;
  import key_ctrl_pkg::*;

  localparam int D = 8;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        key;
  logic        pio_mask = 1'b0;
  logic        key_down;
  logic        press_pulse;
  logic        release_pulse;
  logic [15:0] press_count;
  state_t      dut_state;

  key_pio_ctrl_if bus ();

  key_pio_ctrl #(.DEBOUNCE_CYCLES(D), .POLL_CYCLES(P), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .bus           (bus),
    .key_down      (key_down),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .press_count   (press_count),
    .state         (dut_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // key PIO slave: irq mask register, registered readdata with junk upper bits
  always @(posedge clk) begin
    if (bus.m_chipselect && !bus.m_write_n && bus.m_address == 2'd2)
      pio_mask <= bus.m_writedata[0];
    if (bus.m_address == 2'd0)      bus.m_readdata <= {31'($urandom), key};
    else if (bus.m_address == 2'd2) bus.m_readdata <= {31'($urandom), pio_mask};
    else                            bus.m_readdata <= 32'd0;
  end
  assign bus.irq_in = key & pio_mask;

  // monitors
  int         cyc = 0;
  logic [2:0] exp_q[$];
  logic [2:0] act_q[$];
  int         act_cyc[$];
  int         press_times[$];
  int         release_times[$];
  int         both_high = 0;
  int         wdata_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.m_chipselect && !bus.m_write_n) begin
      act_q.push_back({bus.m_address, bus.m_writedata[0]});
      act_cyc.push_back(cyc);
      if (|bus.m_writedata[31:1]) wdata_hi <= wdata_hi + 1;
    end
    if (press_pulse) press_times.push_back(cyc);
    if (release_pulse) release_times.push_back(cyc);
    if (press_pulse && release_pulse) both_high <= both_high + 1;
  end

  // scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_count = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, " wr_count"}, act_q.size(), exp_q.size());
    while (exp_q.size() > 0 && act_q.size() > 0)
      check({tag, " wr"}, 32'(act_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    act_q.delete();
    act_cyc.delete();
  endtask

  task automatic wait_armed(input string tag);
    int n = 0;
    while (pio_mask !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " armed"}, pio_mask, 1);
  endtask

  // One key press of len cycles. A press is confirmed only if the key is still high when
  // the data register is read D+2 edges after irq; release must follow within P+3 edges.
  task automatic key_trial(input int len, input string tag);
    int   t_rise;
    int   t_fall;
    logic pressed;
    wait_armed(tag);
    press_times.delete();
    release_times.delete();
    @(negedge clk);
    key = 1'b1;
    t_rise = cyc;
    repeat (len) @(negedge clk);
    pressed = (len >= D + 3);
    check({tag, " key_down_at_fall"}, key_down, (len >= D + 4));
    key = 1'b0;
    t_fall = cyc;
    repeat (40) @(negedge clk);
    exp_q.push_back({2'd2, 1'b0});
    exp_q.push_back({2'd2, 1'b1});
    if (pressed) model_count = model_count + 16'd1;
    check({tag, " press_n"}, press_times.size(), pressed);
    if (pressed && press_times.size() > 0)
      check({tag, " press_lat"}, press_times[0] - (t_rise + 1), D + 3);
    check({tag, " release_n"}, release_times.size(), pressed);
    if (pressed && release_times.size() > 0)
      check({tag, " release_win"},
            (release_times[0] - t_fall >= 1) && (release_times[0] - t_fall <= P + 3), 1);
    check({tag, " count"}, press_count, model_count);
    check({tag, " key_down_end"}, key_down, 0);
    check_writes(tag);
  endtask

  initial begin
    int t;
    key    = 1'b0;
    enable = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst key_down", key_down, 0);
    check("rst press_pulse", press_pulse, 0);
    check("rst release_pulse", release_pulse, 0);
    check("rst count", press_count, 0);
    check("rst cs", bus.m_chipselect, 0);
    check("rst write_n", bus.m_write_n, 1);
    check("rst state", 32'(dut_state), 32'(ST_IDLE));

    // enable -> single arm write within 2 cycles
    reset = 1'b0;
    @(negedge clk);
    t = cyc;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    if (act_cyc.size() > 0) check("arm latency", (act_cyc[0] - t <= 2), 1);
    exp_q.push_back({2'd2, 1'b1});
    check_writes("arm");

    // directed presses around the confirmation boundary, then a glitch
    key_trial(40, "hold40");
    key_trial(D + 2, "len10");
    key_trial(D + 3, "len11");
    key_trial(D + 4, "len12");
    key_trial(3, "glitch");

    // randomized press lengths
    for (int i = 0; i < 12; i++) key_trial($urandom_range(1, 24), "rand");

    // enable dropped while the key is held
    wait_armed("stop");
    @(negedge clk);
    key = 1'b1;
    repeat (D + 6) @(negedge clk);
    model_count = model_count + 16'd1;
    check("stop held key_down", key_down, 1);
    enable = 1'b0;
    exp_q.push_back({2'd2, 1'b0});
    exp_q.push_back({2'd2, 1'b0});
    @(negedge clk);
    check("stop release_pulse", release_pulse, 1);
    check("stop key_down", key_down, 0);
    @(negedge clk);
    check("stop state", 32'(dut_state), 32'(ST_IDLE));
    check("stop pulse_width", release_pulse, 0);
    key = 1'b0;
    repeat (10) @(negedge clk);
    check("stop mask", pio_mask, 0);
    check("stop count", press_count, model_count);
    check_writes("stop");
    enable = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back({2'd2, 1'b1});
    check_writes("reenable");

    // press_count wrap from 0xFFFF
    wait_armed("wrap");
    force dut.press_count = 16'hFFFF;
    @(negedge clk);
    release dut.press_count;
    model_count = 16'hFFFF;
    key_trial(15, "wrap");

    // reset during debounce
    wait_armed("rst_mid");
    @(negedge clk);
    key = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_count = 16'd0;
    check("rst_mid key_down", key_down, 0);
    check("rst_mid press_pulse", press_pulse, 0);
    check("rst_mid release_pulse", release_pulse, 0);
    check("rst_mid count", press_count, model_count);
    check("rst_mid cs", bus.m_chipselect, 0);
    check("rst_mid write_n", bus.m_write_n, 1);
    check("rst_mid addr", bus.m_address, 0);
    check("rst_mid wdata", bus.m_writedata, 0);
    check("rst_mid state", 32'(dut_state), 32'(ST_IDLE));
    reset = 1'b0;
    key = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back({2'd2, 1'b0});
    exp_q.push_back({2'd2, 1'b1});
    check_writes("rst_mid");
    key_trial(12, "after_rst");

    check("pulses exclusive", both_high, 0);
    check("wdata upper zero", wdata_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
